// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the round-robin FP32 adder scheduler.
package fp_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPh1  = 2'd1,
      StPh2  = 2'd2,
      StCapt = 2'd3
   } state_e;

   localparam int unsigned FpW       = 32;
   localparam int unsigned AddPhases = 2;

endpackage

// File: rtl/fp_add_sched_if.sv
// Requester/consumer bus of the adder scheduler: per-lane operand handshake plus one response.
interface fp_add_sched_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);
   import fp_sched_pkg::*;

   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*FpW-1:0] req_a;
   logic [NREQ*FpW-1:0] req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [FpW-1:0]      rsp_data;
   logic [IDW-1:0]      rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo NREQ for the first request.
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         grant_o,
   output logic [$clog2(NREQ)-1:0] idx_o,
   output logic                    any_o
);
   localparam int unsigned IdxW = $clog2(NREQ);

   int unsigned     cand;
   logic [IdxW-1:0] cand_idx;

   always_comb begin
      grant_o  = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand     = (32'(ptr_i) + off) % NREQ;
         cand_idx = IdxW'(cand);
         if (!any_o && req_i[cand_idx]) begin
            any_o             = 1'b1;
            idx_o             = cand_idx;
            grant_o[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one two-phase FP32 adder between NREQ requesters; returns sum and requester ID.
module fp_add_sched
   import fp_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic           clk,
   input  logic           reset,
   fp_add_sched_if.slave  bus,
   output logic           add_n_reset_o,
   output logic           add_clk_en_o,
   output logic [FpW-1:0] add_term1_o,
   output logic [FpW-1:0] add_term2_o,
   input  logic [FpW-1:0] add_sum_i,
   input  logic           add_mant_added_i,
   output logic           busy_o,
   output logic           seq_err_o
);

   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, cur_id_q, rsp_id_q;
   logic [FpW-1:0] term1_q, term2_q, rsp_data_q;
   logic           rsp_valid_q, seq_err_q, seq_err_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic            grant_any;
   logic            capture, accept_ok, handshake;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .req_i  (bus.req_valid),
      .ptr_i  (rr_ptr_q),
      .grant_o(grant),
      .idx_o  (grant_idx),
      .any_o  (grant_any)
   );

   // Capture only when the response slot is free or being drained this cycle.
   assign capture       = (state_q == StCapt) && (!rsp_valid_q || bus.rsp_ready);
   assign accept_ok     = (state_q == StIdle) || capture;
   assign handshake     = accept_ok && grant_any;
   assign bus.req_ready = accept_ok ? grant : '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (handshake) state_d = StPh1;
         StPh1:   state_d = StPh2;
         StPh2:   state_d = StCapt;
         StCapt:  if (capture) state_d = handshake ? StPh1 : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      seq_err_d = seq_err_q;
      if (state_q == StPh1 && add_mant_added_i)  seq_err_d = 1'b1;
      if (state_q == StPh2 && !add_mant_added_i) seq_err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= IDW'(NREQ - 1);
         cur_id_q    <= '0;
         term1_q     <= '0;
         term2_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         seq_err_q <= seq_err_d;
         if (handshake) begin
            rr_ptr_q <= grant_idx;
            cur_id_q <= grant_idx;
            term1_q  <= bus.req_a[FpW*grant_idx +: FpW];
            term2_q  <= bus.req_b[FpW*grant_idx +: FpW];
         end
         if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= add_sum_i;
            rsp_id_q    <= cur_id_q;
         end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign add_n_reset_o = ~reset;
   assign add_clk_en_o  = (state_q == StPh1) || (state_q == StPh2);
   assign add_term1_o   = term1_q;
   assign add_term2_o   = term2_q;
   assign busy_o        = (state_q != StIdle);
   assign seq_err_o     = seq_err_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched with a behavioural two-phase FP32 adder.
module tb_fp_add_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        add_n_reset, add_clk_en, add_mant_added, busy, seq_err;
   logic [31:0] add_term1, add_term2, add_sum;
   logic        mant_q, phase_fault;
   logic [31:0] sum_q;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [33:0] sb[$];
   int          glog[$];
   int          gcyc[$];
   logic [33:0] exp_e;

   fp_add_sched_if #(.NREQ(4), .IDW(2)) bus ();

   fp_add_sched #(.NREQ(4), .IDW(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .add_n_reset_o   (add_n_reset),
      .add_clk_en_o    (add_clk_en),
      .add_term1_o     (add_term1),
      .add_term2_o     (add_term2),
      .add_sum_i       (add_sum),
      .add_mant_added_i(add_mant_added),
      .busy_o          (busy),
      .seq_err_o       (seq_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic real fp32_to_real(input logic [31:0] b);
      logic [63:0] d;
      if (b[30:0] == 31'd0) return 0.0;
      d = {b[31], 11'(32'(b[30:23]) + 32'd896), b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real_to_fp32(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      return {d[63], 8'(32'(d[62:52]) - 32'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
   endfunction

   // Behavioural adder: phase toggles on every enabled edge, sum appears after the second.
   always @(posedge clk or negedge add_n_reset) begin
      if (!add_n_reset) begin
         mant_q <= 1'b0;
         sum_q  <= 32'd0;
      end else if (add_clk_en) begin
         if (!mant_q) begin
            mant_q <= 1'b1;
         end else begin
            mant_q <= 1'b0;
            sum_q  <= fp_add(add_term1, add_term2);
         end
      end
   end
   assign add_mant_added = mant_q | phase_fault;
   assign add_sum        = sum_q;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               sb.push_back({2'(i), fp_add(bus.req_a[i*32 +: 32], bus.req_b[i*32 +: 32])});
               glog.push_back(i);
               gcyc.push_back(cyc);
            end
         end
         if (bus.req_ready != 4'd0) check_eq("ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               check_eq("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               exp_e = sb.pop_front();
               check_eq("rsp_id", 64'(bus.rsp_id), 64'(exp_e[33:32]));
               check_eq("rsp_data", 64'(bus.rsp_data), 64'(exp_e[31:0]));
            end
         end
      end
   end

   task automatic send(input int lane, input logic [31:0] a, input logic [31:0] b);
      bit ok = 1'b0;
      bus.req_a[lane*32 +: 32] = a;
      bus.req_b[lane*32 +: 32] = b;
      bus.req_valid[lane]      = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.req_ready[lane]) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid[lane] = 1'b0;
      if (!ok) check_eq("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.rsp_valid && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("drain_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string tag, input logic [31:0] exp);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) check_eq(tag, 64'(bus.rsp_data), 64'(exp));
      else check_eq({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   initial begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      bit ok;
      phase_fault   = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      check_eq("rst_terms", 64'({add_term1, add_term2}), 64'd0);
      check_eq("rst_clk_en", 64'(add_clk_en), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_seq_err", 64'(seq_err), 64'd0);
      check_eq("rst_add_n_reset", 64'(add_n_reset), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // All four lanes valid continuously: round-robin from lane 0
      glog.delete();
      gcyc.delete();
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*32 +: 32] = real_to_fp32(real'(i + 1));
         bus.req_b[i*32 +: 32] = 32'h41200000;
      end
      bus.req_valid = 4'hF;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (glog.size() >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      if (!ok) check_eq("rr_timeout", 64'd0, 64'd1);
      else begin
         for (int i = 0; i < 5; i++) check_eq("rr_order", 64'(glog[i]), 64'(exp_order[i]));
         for (int i = 1; i < 5; i++) check_eq("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
      end
      wait_drain();

      // Single request, exact latency
      bus.req_a[32 +: 32] = 32'h3F800000;
      bus.req_b[32 +: 32] = 32'h40000000;
      bus.req_valid       = 4'b0010;
      @(negedge clk);
      check_eq("single_ready", 64'(bus.req_ready), 64'b0010);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check_eq("single_clk_en", 64'(add_clk_en), 64'(k <= 2));
         check_eq("single_rsp_valid", 64'(bus.rsp_valid), 64'(k == 4));
         if (k == 4) begin
            check_eq("single_data", 64'(bus.rsp_data), 64'h40400000);
            check_eq("single_id", 64'(bus.rsp_id), 64'd1);
         end
      end
      wait_drain();

      // Back-pressure: two operations while the consumer stalls
      bus.rsp_ready = 1'b0;
      send(2, 32'h3FC00000, 32'h40200000);
      send(3, 32'h40C00000, 32'h3F800000);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("bp_busy", 64'(busy), 64'd1);
      check_eq("bp_clk_en", 64'(add_clk_en), 64'd0);
      check_eq("bp_term1", 64'(add_term1), 64'h40C00000);
      check_eq("bp_term2", 64'(add_term2), 64'h3F800000);
      check_eq("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check_eq("bp_hold_data", 64'(bus.rsp_data), 64'h40800000);
      check_eq("bp_hold_id", 64'(bus.rsp_id), 64'd2);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_first_id", 64'(bus.rsp_id), 64'd2);
      @(negedge clk);
      check_eq("bp_second_valid", 64'(bus.rsp_valid), 64'd1);
      check_eq("bp_second_id", 64'(bus.rsp_id), 64'd3);
      check_eq("bp_second_data", 64'(bus.rsp_data), 64'h40E00000);
      @(negedge clk);
      check_eq("bp_empty", 64'(bus.rsp_valid), 64'd0);
      check_eq("bp_nothing_lost", 64'(sb.size()), 64'd0);
      wait_drain();

      // Phase fault during PH1 sets a sticky error
      send(0, 32'h3F800000, 32'h3F800000);
      phase_fault = 1'b1;
      @(negedge clk);
      check_eq("fault_pre", 64'(seq_err), 64'd0);
      @(posedge clk);
      #1;
      phase_fault = 1'b0;
      @(negedge clk);
      check_eq("fault_set", 64'(seq_err), 64'd1);
      wait_drain();

      // Cancel and opposite-sign results pass through unchanged
      send(1, 32'h40400000, 32'hC0400000);
      wait_rsp("cancel_zero", 32'h00000000);
      wait_drain();
      send(2, 32'h40A00000, 32'hC0000000);
      wait_rsp("opp_sign", 32'h40400000);
      wait_drain();
      check_eq("fault_sticky", 64'(seq_err), 64'd1);

      // Reset asserted during PH2
      send(1, 32'h40000000, 32'h40000000);
      @(posedge clk);
      #1;
      check_eq("midrst_in_ph2", 64'(add_clk_en), 64'd1);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check_eq("midrst_busy", 64'(busy), 64'd0);
      check_eq("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_eq("midrst_add_n_reset", 64'(add_n_reset), 64'd0);
      check_eq("midrst_clk_en", 64'(add_clk_en), 64'd0);
      check_eq("midrst_seq_err", 64'(seq_err), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.req_a[0 +: 32]  = 32'h3F800000;
      bus.req_b[0 +: 32]  = 32'h3F800000;
      bus.req_a[96 +: 32] = 32'h40000000;
      bus.req_b[96 +: 32] = 32'h40000000;
      bus.req_valid       = 4'b1001;
      @(negedge clk);
      check_eq("midrst_ptr_grant", 64'(bus.req_ready), 64'b0001);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      wait_rsp("midrst_result", 32'h40000000);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
